// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
// Bytes are accepted over a valid/ready handshake; tx is a registered output that idles high.
// Optional feature macro: UART_TX_PARITY_EN. When defined, a parity bit (even, or odd
// when PARITY_ODD=1) follows the data bits. When undefined, the parity state is absent,
// the frame goes straight from the last data bit to the stop bit(s), and PARITY_ODD is unused.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    // Elaboration-time guards on the legal parameter ranges.
    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be in 1..65535");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;     // data bit index in DATA, stop bit index in STOP
    logic [7:0]  shift_reg;
    logic        baud_wrap;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    // Handshake and status are plain decodes of the registered state.
    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = valid_in && ready;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // Baud counter: held at 0 while idle, counts 0..CLKS_PER_BIT-1 during a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || baud_wrap) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // Frame sequencer: state, bit counter, shift register and the registered tx line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        // Start bit goes out on the accepting edge.
                        shift_reg <= data_in;
                        bit_cnt   <= '0;
                        tx        <= 1'b0;
                        state     <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^data_in) ^ (PARITY_ODD != 0);
`endif
                    end
                end

                START: begin
                    if (baud_wrap) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    tx <= 1'b1;
                    if (baud_wrap) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven bench for uart_tx.
// Four instances with different parameters share clk/rst:
//   u0: CLKS_PER_BIT=4, even parity, 1 stop bit
//   u1: CLKS_PER_BIT=4, odd parity,  1 stop bit
//   u2: CLKS_PER_BIT=1, even parity, 1 stop bit
//   u3: CLKS_PER_BIT=2, even parity, 2 stop bits
// Expected frames are written in transmission order (leftmost digit = first bit on the line);
// the set of tables follows whether UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB [4] = '{4, 4, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in  [4];
    logic       valid_in [4];
    logic       ready    [4];
    logic       tx       [4];
    logic       busy     [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .data_in(data_in[0]), .valid_in(valid_in[0]),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in[1]), .valid_in(valid_in[1]),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));
    uart_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .data_in(data_in[2]), .valid_in(valid_in[2]),
        .ready(ready[2]), .tx(tx[2]), .busy(busy[2]));
    uart_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .data_in(data_in[3]), .valid_in(valid_in[3]),
        .ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [11:0] seq;    // seq[nbits-1] is the first bit on the line
        int          nbits;
        string       name;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
        end
    endtask

    // Entered just after a falling edge; returns just after the falling edge of the
    // cycle following the frame, where ready must be back.
    task automatic send_frame(input int d, input logic [7:0] b, input logic [11:0] seq,
                              input int nbits, input string name);
        chk({name, " ready before"}, ready[d], 1'b1);
        data_in[d]  = b;
        valid_in[d] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < CPB[d]; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) begin
                    valid_in[d] = 1'b0;
                    data_in[d]  = ~b;      // must not disturb the frame in flight
                end
                chk($sformatf("%s tx bit%0d cyc%0d", name, k, c), tx[d], seq[nbits-1-k]);
                chk($sformatf("%s busy bit%0d", name, k), busy[d], 1'b1);
                chk($sformatf("%s ready bit%0d", name, k), ready[d], 1'b0);
            end
        end
        @(negedge clk);
        chk({name, " ready after"}, ready[d], 1'b1);
        chk({name, " busy after"}, busy[d], 1'b0);
        chk({name, " tx after"}, tx[d], 1'b1);
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] f1, f2, rst_seq;
        int          nb;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{0, 8'hA5, 12'(11'b0_10100101_0_1),  11, "a5_even"};
        vecs[1] = '{1, 8'h00, 12'(11'b0_00000000_1_1),  11, "00_odd"};
        vecs[2] = '{0, 8'h07, 12'(11'b0_11100000_1_1),  11, "07_even"};
        vecs[3] = '{3, 8'h81, 12'b0_10000001_0_11,      12, "81_2stop"};
        vecs[4] = '{1, 8'hFF, 12'(11'b0_11111111_1_1),  11, "ff_odd"};
        vecs[5] = '{2, 8'h55, 12'(11'b0_10101010_0_1),  11, "55_cpb1"};
        f1      = 12'(11'b0_10101010_0_1);   // 0x55, even
        f2      = 12'(11'b0_00111100_0_1);   // 0x3C, even
        rst_seq = 12'(11'b0_11111111_0_1);   // 0xFF, even
        nb      = 11;
`else
        vecs[0] = '{0, 8'hA5, 12'(10'b0_10100101_1),   10, "a5"};
        vecs[1] = '{1, 8'h00, 12'(10'b0_00000000_1),   10, "00"};
        vecs[2] = '{0, 8'h07, 12'(10'b0_11100000_1),   10, "07"};
        vecs[3] = '{3, 8'h81, 12'(11'b0_10000001_11),  11, "81_2stop"};
        vecs[4] = '{1, 8'hFF, 12'(10'b0_11111111_1),   10, "ff"};
        vecs[5] = '{2, 8'h55, 12'(10'b0_10101010_1),   10, "55_cpb1"};
        f1      = 12'(10'b0_10101010_1);
        f2      = 12'(10'b0_00111100_1);
        rst_seq = 12'(10'b0_11111111_1);
        nb      = 10;
`endif

        for (int d = 0; d < 4; d++) begin
            data_in[d]  = 8'h00;
            valid_in[d] = 1'b0;
        end

        // Reset, then 20 idle cycles.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("idle tx u%0d", d), tx[d], 1'b1);
                chk($sformatf("idle ready u%0d", d), ready[d], 1'b1);
                chk($sformatf("idle busy u%0d", d), busy[d], 1'b0);
            end
        end

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].dut, vecs[i].data, vecs[i].seq, vecs[i].nbits, vecs[i].name);
            @(negedge clk);
        end

        // Back-to-back on u2 with valid held: frame, one ready cycle, frame.
        chk("b2b ready before", ready[2], 1'b1);
        data_in[2]  = 8'h55;
        valid_in[2] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 2 * nb + 1; k++) begin
            logic exp_tx;
            logic exp_rdy;
            @(negedge clk);
            if (k == 0) data_in[2] = 8'h3C;
            if (k == nb + 1) valid_in[2] = 1'b0;
            if (k < nb) begin
                exp_tx  = f1[nb-1-k];
                exp_rdy = 1'b0;
            end else if (k == nb) begin
                exp_tx  = 1'b1;
                exp_rdy = 1'b1;
            end else begin
                exp_tx  = f2[nb-1-(k-nb-1)];
                exp_rdy = 1'b0;
            end
            chk($sformatf("b2b tx cyc%0d", k), tx[2], exp_tx);
            chk($sformatf("b2b ready cyc%0d", k), ready[2], exp_rdy);
        end
        @(negedge clk);
        chk("b2b ready end", ready[2], 1'b1);
        chk("b2b busy end", busy[2], 1'b0);

        // Reset in the middle of data bit 3 on u0 (bit 3 spans cycles 17..20).
        @(negedge clk);
        data_in[0]  = 8'hA5;
        valid_in[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("midrst tx d3", tx[0], 1'b0);
        chk("midrst busy before", busy[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("midrst tx async", tx[0], 1'b1);
        chk("midrst busy async", busy[0], 1'b0);
        chk("midrst ready async", ready[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        send_frame(0, 8'hFF, rst_seq, nb, "after_rst_ff");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
